dcm_clkgen_prog: RTL and testbench
==================================

Name: dcm_clkgen_prog

Overview:
Drives the DCM_CLKGEN dynamic reprogramming port (PROGEN/PROGDATA, sampled on PROGCLK; PROGDONE returned) so the pixel clock M/D ratio can change at runtime instead of being tied off. On a start request it serially loads D, then M, issues GO, and waits for PROGDONE. Sits beside clk_gen. Its clk also feeds the DCM PROGCLK pin at top level.

Parameters:
TIMEOUT_CYCLES, 65535, maximum cycles in WAIT_DONE before aborting with a timeout error (fits the 16-bit counter).

Ports:
clk  in  1  module clock; also wired to DCM PROGCLK
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
m_minus1  in  8  multiply value M-1 (legal 1..255, i.e. M=2..256)
d_minus1  in  8  divide value D-1 (legal 0..255, i.e. D=1..256)
prog_en  out  1  to DCM PROGEN
prog_data  out  1  to DCM PROGDATA
prog_done  in  1  from DCM PROGDONE
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse (success or error)
err_code  out  2  00 ok, 01 bad config, 10 timeout; held until next accepted start

Behaviour:
- Reset: all outputs 0 on the edge rst is high; state IDLE; counters and flags cleared. Reset mid-operation drops prog_en at that edge with no further bits. The DCM may hold a partial load; the next start reprograms both D and M in full.
- All outputs are registered. m_minus1/d_minus1 are captured into internal registers at the accepted start edge; later input changes are ignored.
- States: IDLE, LOAD_D, GAP1, LOAD_M, GAP2, GO, WAIT_DONE, FINISH.
- IDLE with start=1 and m_minus1==0: go to FINISH. Nothing is driven on prog_*. err_code=01. done pulses on cycle 1 (start at edge 0). busy stays 0.
- IDLE with start=1 and a legal config: err_code cleared to 00. busy=1 from cycle 1.
- LOAD_D, cycles 1..10: prog_en=1. prog_data sequence is 1, 0, then d_minus1[0]..d_minus1[7], LSB first. A 4-bit bit counter runs 0..9.
- GAP1, cycle 11: prog_en=0, prog_data=0.
- LOAD_M, cycles 12..21: prog_en=1. prog_data sequence is 1, 1, then m_minus1[0]..m_minus1[7].
- GAP2, cycle 22: prog_en=0.
- GO, cycle 23: prog_en=1, prog_data=0 for exactly one cycle.
- WAIT_DONE, from cycle 24: prog_en=0 and a 16-bit timeout counter runs.
- seen_low flag: cleared on an accepted start; set on any sampled prog_done==0 from cycle 1 onward.
- Success: in WAIT_DONE, seen_low==1 and prog_done==1 -> FINISH with err_code=00. A prog_done left high from the previous programming never completes early.
- Timeout: counter reaches TIMEOUT_CYCLES-1 with no success -> FINISH with err_code=10. If success and timeout occur on the same cycle, success wins.
- FINISH: done=1 and busy=0 on this cycle, then return to IDLE.
- start while busy or in FINISH: ignored, not queued.
- start is accepted again on the cycle after done, so back-to-back programming is allowed.

Decomposition:
- Shared package dcm_prog_pkg holds:
  - state enum
  - command constants CMD_LOAD_D=2'b01 and CMD_LOAD_M=2'b11, transmitted bit0 first, which gives the 1,0 / 1,1 order
  - LOAD_BITS=10
  - err_code constants ERR_OK, ERR_CFG, ERR_TIMEOUT
- One natural sub-module: dcm_prog_shifter. It takes a 10-bit word plus load and produces the serialized bit and a last-bit flag. The FSM uses it twice, once for D and once for M.

Test Plan:
1. m_minus1=31, d_minus1=63 (M=32, D=64), with the DCM model pulling prog_done low at cycle 5 and high at cycle 40 -> exact stream checked:
   - prog_en high cycles 1-10, 12-21 and 23
   - prog_data on cycles 1-10: 1,0,1,1,1,1,1,1,0,0
   - prog_data on cycles 12-21: 1,1,1,1,1,1,1,0,0,0
   - prog_data=0 on cycle 23
   - done on cycle 41 with err_code=00; busy high on cycles 1-40.
2. m_minus1=0 -> no prog_en activity, done at cycle 1, err_code=01, busy never high.
3. prog_done stuck high throughout, TIMEOUT_CYCLES=100 -> no early completion; done at cycle 24+100, err_code=10.
4. start pulsed again at cycles 5 and 30 during an operation -> ignored; exactly one done; the stream is identical to scenario 1.
5. rst asserted at cycle 15 (inside LOAD_M) -> prog_en=0 from cycle 16; busy, done and err_code read 0. A new start reproduces the full scenario 1 stream.
6. Back-to-back: start again on the cycle after done with m_minus1=255, d_minus1=0 -> accepted; the LOAD_D data bits are all 0 and the LOAD_M data bits are all 1.

Source files
------------

// File: rtl/dcm_prog_pkg.sv
// rtl/dcm_prog_pkg.sv - shared types and constants for the DCM_CLKGEN programming port driver
// Contents: FSM state enum, serial command codes, load word length, error codes.
package dcm_prog_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_D,
        GAP1,
        LOAD_M,
        GAP2,
        GO,
        WAIT_DONE,
        FINISH
    } state_t;

    // Two command bits followed by eight value bits, sent LSB first.
    localparam int LOAD_BITS = 10;

    // Sent bit0 first: LOAD_D goes out as 1,0 and LOAD_M as 1,1.
    localparam logic [1:0] CMD_LOAD_D = 2'b01;
    localparam logic [1:0] CMD_LOAD_M = 2'b11;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_CFG     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/dcm_prog_shifter.sv
// rtl/dcm_prog_shifter.sv - LSB-first serializer for one DCM load word
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   load        capture word and restart the bit counter
//   shift       advance to the next bit
//   word        command+value word to serialize
//   bit_out     current serial bit (registered)
//   last        high while the final bit is on bit_out
module dcm_prog_shifter
    import dcm_prog_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 shift,
    input  logic [LOAD_BITS-1:0] word,
    output logic                 bit_out,
    output logic                 last
);

    logic [LOAD_BITS-1:0] sh;
    logic [3:0]           cnt;

    // Zeros are shifted in, so one shift past the last bit leaves bit_out low
    // for the gap and GO cycles without extra clearing logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh  <= '0;
            cnt <= '0;
        end else if (load) begin
            sh  <= word;
            cnt <= '0;
        end else if (shift) begin
            sh  <= {1'b0, sh[LOAD_BITS-1:1]};
            cnt <= last ? cnt : cnt + 4'd1;
        end
    end

    assign bit_out = sh[0];
    assign last    = (cnt == 4'(LOAD_BITS - 1));

endmodule

// File: rtl/dcm_clkgen_prog.sv
// rtl/dcm_clkgen_prog.sv - runtime M/D reprogramming driver for DCM_CLKGEN
// Ports:
//   clk        module clock, also DCM PROGCLK
//   rst        synchronous active-high reset
//   start      one-cycle request, honoured only in IDLE
//   m_minus1   multiply value M-1 (0 is rejected)
//   d_minus1   divide value D-1
//   prog_en    DCM PROGEN
//   prog_data  DCM PROGDATA
//   prog_done  DCM PROGDONE
//   busy       operation in progress
//   done       one-cycle completion pulse
//   err_code   result of last operation, held until next accepted start
module dcm_clkgen_prog
    import dcm_prog_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] m_minus1,
    input  logic [7:0] d_minus1,
    output logic       prog_en,
    output logic       prog_data,
    input  logic       prog_done,
    output logic       busy,
    output logic       done,
    output logic [1:0] err_code
);

    state_t         state;
    state_t         next_state;
    logic [7:0]     m_reg;
    logic           seen_low;
    logic [15:0]    timer;

    logic           cfg_bad;
    logic           success;
    logic           timeout;
    logic           sh_load;
    logic           sh_shift;
    logic           sh_last;
    logic [LOAD_BITS-1:0] sh_word;

    logic           en_nx;
    logic           busy_nx;
    logic           done_nx;
    logic [1:0]     err_nx;

    assign cfg_bad = (m_minus1 == 8'd0);
    // seen_low guards against a PROGDONE still high from the previous load.
    assign success = seen_low && prog_done;
    assign timeout = (timer == 16'(TIMEOUT_CYCLES - 1));

    dcm_prog_shifter u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load    (sh_load),
        .shift   (sh_shift),
        .word    (sh_word),
        .bit_out (prog_data),
        .last    (sh_last)
    );

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            prog_en  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err_code <= ERR_OK;
        end else begin
            state    <= next_state;
            prog_en  <= en_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            err_code <= err_nx;
        end
    end

    // Datapath: captured M, PROGDONE-low tracker, wait timer
    always_ff @(posedge clk) begin
        if (rst) begin
            m_reg    <= '0;
            seen_low <= 1'b0;
            timer    <= '0;
        end else begin
            if (state == IDLE && start) begin
                m_reg    <= m_minus1;
                seen_low <= 1'b0;
            end else if (state != IDLE && !prog_done) begin
                seen_low <= 1'b1;
            end
            timer <= (state == WAIT_DONE) ? timer + 16'd1 : 16'd0;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (start) next_state = cfg_bad ? FINISH : LOAD_D;
            LOAD_D:    if (sh_last) next_state = GAP1;
            GAP1:      next_state = LOAD_M;
            LOAD_M:    if (sh_last) next_state = GAP2;
            GAP2:      next_state = GO;
            GO:        next_state = WAIT_DONE;
            WAIT_DONE: if (success || timeout) next_state = FINISH;
            FINISH:    next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Output logic: values for the next cycle, registered above.
    // D is loaded straight from the port on the accepting edge; M is loaded
    // from its captured copy during GAP1.
    always_comb begin
        sh_load  = (state == IDLE && start && !cfg_bad) || (state == GAP1);
        sh_shift = (state == LOAD_D) || (state == LOAD_M);
        sh_word  = (state == IDLE) ? {d_minus1, CMD_LOAD_D} : {m_reg, CMD_LOAD_M};
        en_nx    = (next_state == LOAD_D) || (next_state == LOAD_M) || (next_state == GO);
        busy_nx  = (next_state != IDLE) && (next_state != FINISH);
        done_nx  = (next_state == FINISH);
        err_nx   = err_code;
        if (state == IDLE && start) begin
            err_nx = cfg_bad ? ERR_CFG : ERR_OK;
        end else if (state == WAIT_DONE) begin
            if (success) begin
                err_nx = ERR_OK;
            end else if (timeout) begin
                err_nx = ERR_TIMEOUT;
            end
        end
    end

endmodule

// File: tb/tb_dcm_clkgen_prog.sv
// tb/tb_dcm_clkgen_prog.sv - self-checking bench for dcm_clkgen_prog
module tb_dcm_clkgen_prog;

    localparam int TMO  = 100;
    localparam int MAXC = 400;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] m_minus1;
    logic [7:0] d_minus1;
    logic       prog_en;
    logic       prog_data;
    logic       prog_done;
    logic       busy;
    logic       done;
    logic [1:0] err_code;

    int checks = 0;
    int errors = 0;

    // Per-cycle prog_done drive and expected {prog_en, prog_data, busy, done, err_code}
    logic       pd   [0:MAXC];
    logic [5:0] expv [0:MAXC];
    int         exp_done_c;

    typedef struct {
        string      name;
        logic [7:0] m;
        logic [7:0] d;
        int         low_at;
        int         high_at;
        int         x1;
        int         x2;
        int         exp_done;
        logic [1:0] exp_err;
    } vec_t;

    vec_t tbl [4];

    dcm_clkgen_prog #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .m_minus1  (m_minus1),
        .d_minus1  (d_minus1),
        .prog_en   (prog_en),
        .prog_data (prog_data),
        .prog_done (prog_done),
        .busy      (busy),
        .done      (done),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int cyc, input logic [5:0] got, input logic [5:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got en/dat/busy/done/err=%b, expected %b", name, cyc, got, want);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Bit stream the DCM should see on cycle c (1..23) after a legal start.
    task automatic stream_bit(input logic [7:0] m, input logic [7:0] d, input int c,
                              output logic en, output logic dat);
        int p;
        p   = c - 1;
        en  = 1'b0;
        dat = 1'b0;
        if (p < 10) begin
            en  = 1'b1;
            dat = (p == 0) ? 1'b1 : (p == 1) ? 1'b0 : d[p-2];
        end else if (p >= 11 && p < 21) begin
            en  = 1'b1;
            dat = (p - 11 < 2) ? 1'b1 : m[p-13];
        end else if (p == 22) begin
            en  = 1'b1;
        end
    endtask

    // Expected outputs from the written rules: serial stream, then wait for
    // PROGDONE high after some earlier low, bounded by the timeout.
    task automatic model(input logic [7:0] m, input logic [7:0] d);
        logic       seen;
        int         fin;
        logic [1:0] ev;
        logic       en;
        logic       dat;
        for (int c = 0; c <= MAXC; c++) expv[c] = 6'b0;
        if (m == 8'd0) begin
            expv[1] = 6'b000101;
            for (int c = 2; c <= MAXC; c++) expv[c] = 6'b000001;
            exp_done_c = 1;
        end else begin
            seen = 1'b0;
            fin  = 24 + TMO - 1;
            ev   = 2'b10;
            for (int c = 1; c <= 24 + TMO - 1; c++) begin
                if (c >= 24 && seen && pd[c]) begin
                    fin = c;
                    ev  = 2'b00;
                    break;
                end
                if (!pd[c]) seen = 1'b1;
            end
            for (int c = 1; c <= fin; c++) begin
                en  = 1'b0;
                dat = 1'b0;
                if (c <= 23) stream_bit(m, d, c, en, dat);
                expv[c] = {en, dat, 1'b1, 1'b0, 2'b00};
            end
            expv[fin+1] = {4'b0001, ev};
            for (int c = fin + 2; c <= MAXC; c++) expv[c] = {4'b0000, ev};
            exp_done_c = fin + 1;
        end
    endtask

    // One operation: start sampled at edge 0; inputs for cycle k are sampled
    // at edge k, and the outputs visible after edge k belong to cycle k+1.
    task automatic run_op(input string name, input logic [7:0] m, input logic [7:0] d,
                          input int low_at, input int high_at, input int x1, input int x2,
                          input int rst_at, output int seen_done, output logic [1:0] seen_err);
        int last;
        for (int k = 0; k <= MAXC; k++) pd[k] = (k >= low_at && k < high_at) ? 1'b0 : 1'b1;
        model(m, d);
        seen_done = -1;
        seen_err  = 2'b11;
        last = (rst_at >= 0) ? rst_at : exp_done_c;
        for (int k = 0; k <= last; k++) begin
            if (k == 0) begin
                m_minus1 = m;
                d_minus1 = d;
            end else begin
                m_minus1 = 8'($urandom);
                d_minus1 = 8'($urandom);
            end
            start     = (k == 0 || k == x1 || k == x2);
            prog_done = pd[k];
            rst       = (k == rst_at);
            @(posedge clk);
            #1;
            if (k == rst_at) begin
                chk({name, "_reset"}, k + 1, {prog_en, prog_data, busy, done, err_code}, 6'b0);
            end else begin
                chk(name, k + 1, {prog_en, prog_data, busy, done, err_code}, expv[k+1]);
            end
            if (done && seen_done < 0) begin
                seen_done = k + 1;
                seen_err  = err_code;
            end
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int         sd;
        logic [1:0] se;
        logic [7:0] rm;
        logic [7:0] rd;
        int         la;
        int         ha;

        tbl[0] = '{"basic",   8'd31, 8'd63, 5, 40, -1, -1, 41,         2'b00};
        tbl[1] = '{"bad_cfg", 8'd0,  8'd63, 5, 40, -1, -1, 1,          2'b01};
        tbl[2] = '{"timeout", 8'd31, 8'd63, 0, 0,  -1, -1, 24 + TMO,   2'b10};
        tbl[3] = '{"restart", 8'd31, 8'd63, 5, 40, 5,  30, 41,         2'b00};

        rst       = 1'b1;
        start     = 1'b0;
        prog_done = 1'b1;
        m_minus1  = 8'd0;
        d_minus1  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 0, {prog_en, prog_data, busy, done, err_code}, 6'b0);
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 4; i++) begin
            run_op(tbl[i].name, tbl[i].m, tbl[i].d, tbl[i].low_at, tbl[i].high_at,
                   tbl[i].x1, tbl[i].x2, -1, sd, se);
            chk_int({tbl[i].name, "_done_cycle"}, sd, tbl[i].exp_done);
            chk_int({tbl[i].name, "_err"}, int'(se), int'(tbl[i].exp_err));
            idle(3);
        end

        // Reset inside LOAD_D/LOAD_M window, then a clean rerun
        run_op("mid_reset", 8'd31, 8'd63, 5, 40, -1, -1, 15, sd, se);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("after_reset", i, {prog_en, prog_data, busy, done, err_code}, 6'b0);
        end
        run_op("rerun", 8'd31, 8'd63, 5, 40, -1, -1, -1, sd, se);
        chk_int("rerun_done_cycle", sd, 41);

        // Back-to-back: next start on the cycle right after done
        run_op("b2b", 8'd255, 8'd0, 5, 40, -1, -1, -1, sd, se);
        chk_int("b2b_done_cycle", sd, 41);
        chk_int("b2b_err", int'(se), 0);
        idle(2);

        for (int i = 0; i < 20; i++) begin
            rm = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            rd = 8'($urandom);
            la = $urandom_range(1, 60);
            ha = la + $urandom_range(1, 120);
            run_op("random", rm, rd, la, ha, -1, -1, -1, sd, se);
            chk_int("random_done_cycle", sd, exp_done_c);
            idle($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
